// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divider: op encodings and the FSM state type
// (also consumed by the hazard/stall logic).
package div_unit_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivCalc = 2'd1,
    DivFix  = 2'd2,
    DivDone = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the
// divisor when the difference stays non-negative.
module div_step
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic            quo_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem_in[XLEN-1:0], dividend_bit};
  assign diff    = shifted - {1'b0, divisor};
  // A set top bit means the shifted value already exceeds any 32-bit divisor.
  assign quo_bit = rem_in[XLEN] | ~diff[XLEN];
  assign rem_out = quo_bit ? diff : shifted;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit divider for DIV/DIVU/REM/REMU: 32 restoring iterations on
// magnitudes, then a sign-fix cycle; divide-by-zero and overflow finish at accept.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);

  div_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            want_rem_q, want_rem_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN:0]   rem_q, rem_d;

  logic            signed_op, a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] a_abs, b_abs, special_res, quo_fix, rem_fix;
  logic [XLEN:0]   step_rem;
  logic            step_bit;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[XLEN-1];
  assign b_neg     = signed_op & b[XLEN-1];
  assign a_abs     = a_neg ? (~a + 1'b1) : a;
  assign b_abs     = b_neg ? (~b + 1'b1) : b;
  assign div_zero  = (b == '0);
  assign overflow  = signed_op && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

  // Div-by-zero: q = all ones, r = a. Overflow: q = a (most negative), r = 0.
  assign special_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

  div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_in      (rem_q),
    .dividend_bit(quo_q[XLEN-1]),
    .divisor     (dvs_q),
    .rem_out     (step_rem),
    .quo_bit     (step_bit)
  );

  assign quo_fix = q_neg_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = r_neg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    want_rem_d = want_rem_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    result_d   = result_q;

    unique case (state_q)
      DivIdle, DivDone: begin
        if (start) begin
          want_rem_d = op[1];
          q_neg_d    = a_neg ^ b_neg;
          r_neg_d    = a_neg;
          quo_d      = a_abs;
          dvs_d      = b_abs;
          rem_d      = '0;
          cnt_d      = '0;
          if (div_zero || overflow) begin
            result_d = special_res;
            state_d  = DivDone;
          end else begin
            state_d = DivCalc;
          end
        end else begin
          state_d = DivIdle;
        end
      end
      DivCalc: begin
        rem_d = step_rem;
        quo_d = {quo_q[XLEN-2:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          state_d = DivFix;
        end
      end
      DivFix: begin
        result_d = want_rem_q ? rem_fix : quo_fix;
        state_d  = DivDone;
      end
      default: state_d = DivIdle;
    endcase

    // Flush wins over everything, including a same-cycle start.
    if (kill) begin
      state_d  = DivIdle;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DivIdle;
      cnt_q      <= '0;
      want_rem_q <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      quo_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      want_rem_q <= want_rem_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      result_q   <= result_d;
    end
  end

  assign busy   = (state_q == DivCalc) || (state_q == DivFix);
  assign done   = (state_q == DivDone);
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table for results and latency, plus
// hand-written kill, ignored-start, back-to-back and async-reset sequences.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_unit #(
    .XLEN(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .kill  (kill),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a request; returns #1 after the accepting edge E0.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded); busy_cycles counts busy samples.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (!done && cycles < 60) begin
      if (busy) busy_cycles++;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] res, input int lat);
    int c, bc;
    issue(o, x, y);
    wait_done(c, bc);
    check({name, " latency"}, 32'(c), 32'(lat));
    check({name, " busy cycles"}, 32'(bc), 32'(lat));
    check({name, " result"}, result, res);
    @(posedge clk);
    #1;
    check({name, " done one cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int c, bc, seen;

    vecs[0]  = '{DIV_OP_DIV,  32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 33};
    vecs[1]  = '{DIV_OP_REM,  32'd20,         32'hFFFF_FFFD, 32'd2,         33};
    vecs[2]  = '{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 33};
    vecs[3]  = '{DIV_OP_REMU, 32'hFFFF_FFFF,  32'd2,         32'd1,         33};
    vecs[4]  = '{DIV_OP_DIV,  32'd7,          32'd0,         32'hFFFF_FFFF, 0};
    vecs[5]  = '{DIV_OP_REM,  32'd7,          32'd0,         32'd7,         0};
    vecs[6]  = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0};
    vecs[7]  = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0};
    vecs[8]  = '{DIV_OP_DIVU, 32'd100,        32'd7,         32'd14,        33};
    vecs[9]  = '{DIV_OP_DIV,  32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 33};
    vecs[10] = '{DIV_OP_REM,  32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 33};
    vecs[11] = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         33};
    vecs[12] = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 33};
    vecs[13] = '{DIV_OP_DIVU, 32'd5,          32'd0,         32'hFFFF_FFFF, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].lat);
    end

    // Kill 10 cycles after E0: no done, result keeps the prior value (14)
    run_op("kill prior", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    issue(DIV_OP_DIV, 32'd20, 32'hFFFF_FFFD);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill busy", {31'd0, busy}, 32'd0);
    check("kill done", {31'd0, done}, 32'd0);
    check("kill result", result, 32'd14);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    check("kill no later done", 32'(seen), 32'd0);
    check("kill result held", result, 32'd14);

    // Start during CALC is ignored
    issue(DIV_OP_DIVU, 32'd1000, 32'd7);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    op = DIV_OP_DIV;
    a = 32'd7;
    b = 32'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(c, bc);
    check("ignored start latency", 32'(c + 5), 32'd33);
    check("ignored start result", result, 32'd142);
    @(posedge clk);
    #1;
    run_op("fresh divu", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    // Back-to-back: accept in DONE, no idle gap
    issue(DIV_OP_DIVU, 32'd100, 32'd7);
    wait_done(c, bc);
    check("b2b first result", result, 32'd14);
    op = DIV_OP_REMU;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b busy no gap", {31'd0, busy}, 32'd1);
    check("b2b result held", result, 32'd14);
    wait_done(c, bc);
    check("b2b second latency", 32'(c), 32'd33);
    check("b2b second result", result, 32'd2);
    op = DIV_OP_DIV;
    a = 32'd7;
    b = 32'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b special done", {31'd0, done}, 32'd1);
    check("b2b special busy", {31'd0, busy}, 32'd0);
    check("b2b special result", result, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("b2b special done drop", {31'd0, done}, 32'd0);

    // Async reset mid-CALC
    issue(DIV_OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst done", {31'd0, done}, 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1;
    end
    check("after rst quiet", 32'(seen), 32'd0);
    run_op("after rst divu", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
